dprf_arb: RTL

DPRF_ARB -- requirements
Module: dprf_arb

---
 rtl/dprf_arb.sv | 106 ++++++++++
 1 files changed

// File: rtl/dprf_arb.sv
`default_nettype none
// ============================================================================
// Module  : dprf_arb
// Brief   : Two-requester arbiter sharing one synchronous RAM port; one
//           access per three cycles, round-robin or fixed-priority selection.
// Revision: 1.0
// ============================================================================
module dprf_arb #(
  parameter int AW   = 14,
  parameter int PRIO = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_d,
  output logic [7:0]    a_q,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_d,
  output logic [7:0]    b_q,
  output logic          b_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_d,
  input  logic [7:0]    mem_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t state_q;
  logic   gnt_q;   // holds the current grant during an access, and the last grant otherwise
  logic   gnt_d;

  generate
    if (PRIO == 1) begin : g_fixed
      assign gnt_d = a_req ? GNT_A : GNT_B;
    end else begin : g_rr
      assign gnt_d = (a_req && b_req) ? ~gnt_q : (b_req ? GNT_B : GNT_A);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_B;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (a_req || b_req) begin
            gnt_q   <= gnt_d;
            mem_we  <= (gnt_d == GNT_B) ? b_we   : a_we;
            mem_a   <= (gnt_d == GNT_B) ? b_addr : a_addr;
            mem_d   <= (gnt_d == GNT_B) ? b_d    : a_d;
            state_q <= S_ISSUE;
          end else begin
            mem_we <= 1'b0;
          end
        end
        S_ISSUE: begin
          // The RAM performs the access at this edge; a write must not repeat.
          mem_we  <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (gnt_q == GNT_B) begin
            b_q   <= mem_q;
            b_ack <= 1'b1;
          end else begin
            a_q   <= mem_q;
            a_ack <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          mem_we  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire
